// File: rtl/storage_bank.sv
// storage_bank: DEPTH x WIDTH register bank with record, copy, step and serial transfer.
// Define STORAGE_ROTATE_EN to feed the destination LSB back into the source MSB (swap on transfer).
module storage_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             key0_rst,
  input  logic             record,
  input  logic             copy,
  input  logic             step,
  input  logic             transfer,
  input  logic [SEL_W-1:0] sel_src,
  input  logic [SEL_W-1:0] sel_dst,
  input  logic [WIDTH-1:0] sw,
  input  logic             sin,
  output logic [WIDTH-1:0] src_q,
  output logic [WIDTH-1:0] dst_q,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;
  logic [WIDTH-1:0] bank [DEPTH];
  logic [SEL_W-1:0] src_l, dst_l, a, b;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] s_sh, d_sh;
  logic msb_in, any, same;
  assign src_q = bank[sel_src];
  assign dst_q = bank[sel_dst];
  assign any = record | copy | step | transfer;
  assign same = sel_src == sel_dst;
  // The shift datapath follows the latched pair while shifting, the live selectors otherwise.
  assign a = (state == SHIFT) ? src_l : sel_src;
  assign b = (state == SHIFT) ? dst_l : sel_dst;
`ifdef STORAGE_ROTATE_EN
  assign msb_in = bank[b][0];
`else
  assign msb_in = sin;
`endif
  assign s_sh = {msb_in, bank[a][WIDTH-1:1]};
  assign d_sh = {bank[a][0], bank[b][WIDTH-1:1]};
  always_ff @(posedge clk or negedge key0_rst) begin
    if (!key0_rst) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      src_l <= '0;
      dst_l <= '0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      if (state == SHIFT) begin
        err <= any;
        bank[a] <= s_sh;
        bank[b] <= d_sh;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state <= IDLE;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (record) begin
        bank[sel_src] <= sw;
      end else if ((transfer | step | copy) && same) begin
        err <= 1'b1;
      end else if (transfer) begin
        src_l <= sel_src;
        dst_l <= sel_dst;
        cnt <= CW'(WIDTH);
        state <= SHIFT;
        busy <= 1'b1;
      end else if (step) begin
        bank[a] <= s_sh;
        bank[b] <= d_sh;
      end else if (copy) begin
        bank[sel_dst] <= bank[sel_src];
      end
    end
  end
endmodule

// File: tb/tb_storage_bank.sv
// tb_storage_bank: randomized self-checking bench for storage_bank against a word-level model.
module tb_storage_bank;
  localparam int W = 8, D = 4;
  logic clk = 0, key0_rst = 0, record = 0, copy = 0, step = 0, transfer = 0, sin = 0;
  logic [1:0] sel_src = 0, sel_dst = 0;
  logic [7:0] sw = 0, src_q, dst_q;
  logic busy, done, err;
  int errors = 0, checks = 0;
  logic [7:0] m [D];

  storage_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .key0_rst(key0_rst), .record(record), .copy(copy), .step(step),
    .transfer(transfer), .sel_src(sel_src), .sel_dst(sel_dst), .sw(sw), .sin(sin),
    .src_q(src_q), .dst_q(dst_q), .busy(busy), .done(done), .err(err)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One serial shift: source moves right taking a new MSB, destination receives the source LSB.
  task automatic model_shift(input int s, input int d, input logic b);
    logic [7:0] os, od;
    os = m[s];
    od = m[d];
`ifdef STORAGE_ROTATE_EN
    m[s] = (os >> 1) | (8'(od[0]) << 7);
`else
    m[s] = (os >> 1) | (8'(b) << 7);
`endif
    m[d] = (od >> 1) | (8'(os[0]) << 7);
  endtask

  task automatic check_all(input string tag);
    for (int w = 0; w < D; w++) begin
      sel_src = 2'(w);
      sel_dst = 2'(w + 1);
      #1;
      check($sformatf("%s_src%0d", tag, w), src_q, m[w]);
      check($sformatf("%s_dst%0d", tag, (w + 1) % D), dst_q, m[(w + 1) % D]);
    end
  endtask

  task automatic cmd(input logic r, input logic c, input logic st, input int s, input int d,
                     input logic [7:0] v, input logic b);
    logic e;
    record = r; copy = c; step = st;
    sel_src = 2'(s); sel_dst = 2'(d); sw = v; sin = b;
    @(negedge clk);
    record = 0; copy = 0; step = 0;
    e = 0;
    if (r) m[s] = v;
    else if ((c || st) && s == d) e = 1;
    else if (st) model_shift(s, d, b);
    else if (c) m[d] = m[s];
    check("cmd_err", err, e);
    check("cmd_busy", busy, 0);
    check_all("cmd");
  endtask

  task automatic run_transfer(input int s, input int d, input bit rand_sin, input bit inject);
    int nb;
    logic b;
    nb = 0;
    transfer = 1; sel_src = 2'(s); sel_dst = 2'(d); sin = 0;
    @(negedge clk);
    transfer = 0;
    check("tr_accept_err", err, 0);
    for (int k = 0; k < W; k++) begin
      if (busy === 1'b1) nb++;
      b = rand_sin ? 1'($urandom_range(0, 1)) : 1'b0;
      sin = b;
      sel_src = 2'($urandom);
      sel_dst = 2'($urandom);
      sw = 8'($urandom);
      record = inject && k == 2;
      @(negedge clk);
      record = 0;
      model_shift(s, d, b);
      check("tr_rej_err", err, 32'(inject && k == 2));
    end
    check("tr_busy_cycles", nb, W);
    check("tr_busy_end", busy, 0);
    check("tr_done", done, 1);
    @(negedge clk);
    check("tr_done_once", done, 0);
    check_all("tr");
  endtask

  initial begin
    for (int i = 0; i < D; i++) m[i] = 0;
    repeat (2) @(negedge clk);
    key0_rst = 1;
    @(negedge clk);
    cmd(1, 0, 0, 1, 0, 8'hA5, 0);
    cmd(1, 0, 0, 3, 0, 8'h77, 0);
    // asynchronous reset asserted while clk is high, checked before any further edge
    @(posedge clk);
    #3 key0_rst = 0;
    #1;
    for (int i = 0; i < D; i++) m[i] = 0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check_all("rst");
    @(negedge clk);
    key0_rst = 1;
    @(negedge clk);
    cmd(1, 0, 0, 1, 0, 8'hA5, 0);
    cmd(0, 1, 0, 1, 2, 8'h00, 0);
    cmd(1, 0, 0, 2, 0, 8'h00, 0);
    cmd(0, 0, 1, 1, 2, 8'h00, 1);
    cmd(1, 0, 0, 1, 0, 8'hA5, 0);
    cmd(1, 0, 0, 3, 0, 8'h3C, 0);
    run_transfer(1, 3, 0, 0);
    cmd(1, 0, 0, 1, 0, 8'hA5, 0);
    cmd(1, 0, 0, 3, 0, 8'h3C, 0);
    run_transfer(1, 3, 0, 1);
    cmd(0, 1, 0, 2, 2, 8'h00, 0);
    cmd(1, 1, 0, 2, 0, 8'h5A, 0);
    cmd(1, 0, 0, 0, 0, 8'hC3, 0);
    transfer = 1; sel_src = 0; sel_dst = 2;
    @(negedge clk);
    transfer = 0;
    repeat (3) @(negedge clk);
    #3 key0_rst = 0;
    #1;
    for (int i = 0; i < D; i++) m[i] = 0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check_all("mid_rst");
    @(negedge clk);
    key0_rst = 1;
    @(negedge clk);
    check("mid_rst_no_done", done, 0);
    cmd(1, 0, 0, 0, 0, 8'h96, 0);
    run_transfer(0, 1, 1, 0);
    repeat (40) begin
      int s, d;
      s = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) begin
        if (s == d) begin
          transfer = 1; sel_src = 2'(s); sel_dst = 2'(d);
          @(negedge clk);
          transfer = 0;
          check("tr_same_err", err, 1);
          check("tr_same_busy", busy, 0);
          check_all("tr_same");
        end else run_transfer(s, d, 1, 1'($urandom_range(0, 1)));
      end else
        cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            s, d, 8'($urandom), 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
